// File: rtl/mpu_clock_gen_pkg.sv
// Shared types and constants for the MPU clock-enable generator.
package mpu_clock_gen_pkg;

  typedef enum logic [1:0] {CLK_RUN, CLK_HALT, CLK_STEP} mpu_clk_state_t;

  // MODULUS/INC pair giving exactly 32.768 kHz from the 99.287 MHz system clock
  localparam int unsigned MPU_CLK_MODULUS_EXACT = 99_287_040;
  localparam int unsigned MPU_CLK_INC_EXACT     = 32_768;

endpackage

// File: rtl/mpu_clock_gen_phase_acc.sv
// Phase accumulator: adds inc_eff on each advancing cycle, wraps at MODULUS
// keeping the remainder, and registers a one-cycle clk_en on every wrap.
module mpu_phase_acc #(
  parameter int ACC_WIDTH = 27,
  parameter int MODULUS   = 3060
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 advance_i,
  input  logic [ACC_WIDTH-1:0] inc_eff_i,
  output logic                 clk_en_o,
  output logic                 wrap_o
);

  localparam logic [ACC_WIDTH-1:0] MOD = ACC_WIDTH'(MODULUS);

  logic [ACC_WIDTH-1:0] acc_q, acc_d, sum;
  logic                 clk_en_q, clk_en_d;

  // Next accumulator value; remainder is carried so the long-run rate is exact
  always_comb begin
    sum      = acc_q + inc_eff_i;
    wrap_o   = (sum >= MOD);
    acc_d    = acc_q;
    clk_en_d = 1'b0;
    if (advance_i) begin
      acc_d    = wrap_o ? (sum - MOD) : sum;
      clk_en_d = wrap_o;
    end
  end

  // Accumulator and enable registers
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      clk_en_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      clk_en_q <= clk_en_d;
    end
  end

  assign clk_en_o = clk_en_q;

endmodule

// File: rtl/mpu_clock_gen.sv
// MPU clock-enable generator: run/halt/single-step control around a phase
// accumulator, plus a sub-divided tick. Optional turbo multiplier is built
// only when MPU_CLOCK_TURBO_EN is defined.
module mpu_clock_gen
  import mpu_clock_gen_pkg::*;
#(
  parameter int ACC_WIDTH    = 27,
  parameter int MODULUS      = 3060,
  parameter int INC          = 1,
  parameter int SUB_DIV      = 32,
  parameter bit START_HALTED = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       halt,
  input  logic       step,
  input  logic [1:0] turbo_sel,
  output logic       clk_en,
  output logic       sub_tick,
  output logic       halted
);

  localparam mpu_clk_state_t RST_STATE = START_HALTED ? CLK_HALT : CLK_RUN;
  localparam int SW = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(SUB_DIV - 1);

  mpu_clk_state_t       state_q, state_d;
  logic                 advance, wrap;
  logic [ACC_WIDTH-1:0] inc_eff;
  logic [SW-1:0]        sub_cnt_q, sub_cnt_d;
  logic                 sub_tick_q, sub_tick_d;

`ifdef MPU_CLOCK_TURBO_EN
  assign inc_eff = ACC_WIDTH'(INC) << turbo_sel;
`else
  logic turbo_unused;
  assign turbo_unused = ^turbo_sel;
  assign inc_eff      = ACC_WIDTH'(INC);
`endif

  mpu_phase_acc #(
    .ACC_WIDTH (ACC_WIDTH),
    .MODULUS   (MODULUS)
  ) u_acc (
    .clk       (clk),
    .reset     (reset),
    .advance_i (advance),
    .inc_eff_i (inc_eff),
    .clk_en_o  (clk_en),
    .wrap_o    (wrap)
  );

  // Run/halt/step control; halt freezes the accumulator in the cycle it is seen
  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    case (state_q)
      CLK_RUN: begin
        if (halt) state_d = CLK_HALT;
        else      advance = 1'b1;
      end
      CLK_HALT: begin
        if (!halt)     state_d = CLK_RUN;
        else if (step) state_d = CLK_STEP;
      end
      CLK_STEP: begin
        advance = 1'b1;
        if (!halt)     state_d = CLK_RUN;   // pending step merges into running
        else if (wrap) state_d = CLK_HALT;  // one enable released, back to halt
      end
      default: state_d = RST_STATE;
    endcase
  end

  // Sub-divider: counts produced enables, ticks alongside every SUB_DIV-th one
  always_comb begin
    sub_cnt_d  = sub_cnt_q;
    sub_tick_d = 1'b0;
    if (advance && wrap) begin
      if (sub_cnt_q == SUB_LAST) begin
        sub_cnt_d  = '0;
        sub_tick_d = 1'b1;
      end else begin
        sub_cnt_d = sub_cnt_q + SW'(1);
      end
    end
  end

  // State and sub-divider registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RST_STATE;
      sub_cnt_q  <= '0;
      sub_tick_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sub_cnt_q  <= sub_cnt_d;
      sub_tick_q <= sub_tick_d;
    end
  end

  assign sub_tick = sub_tick_q;
  assign halted   = (state_q != CLK_RUN);

endmodule
